temporizador_mmss: RTL and testbench
====================================

TEMPORIZADOR_MMSS -- requirements
Module: temporizador_mmss

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flops on slow_in; legal range 2..4.
REQ-002 SHALL have port clk, input, 1: system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset; one clock, reset is asynchronous and active-low.
REQ-004 SHALL have port slow_in, input, 1: ~1 Hz square wave from the ripple divider, asynchronous to clk.
REQ-005 SHALL have port load, input, 1: load preset value, level-sampled.
REQ-006 SHALL have port start, input, 1: start request, level-sampled.
REQ-007 SHALL have port pause, input, 1: pause/resume toggle request, level-sampled.
REQ-008 SHALL have ports set_mt (3 bits), set_mu (4), set_st (3), set_su (4), inputs: preset minutes tens/units and seconds tens/units, BCD.
REQ-009 SHALL have ports min_t (3), min_u (4), sec_t (3), sec_u (4), outputs: current count, BCD, registered.
REQ-010 SHALL have port running, output, 1: high while in RUN.
REQ-011 SHALL have port done, output, 1: high while in DONE.
REQ-012 SHALL have port tick, output, 1: one-clk pulse per detected slow_in rising edge, for debug.

Function
REQ-013 SHALL pass slow_in through SYNC_STAGES flops plus one history flop; tick = sync_out AND NOT history.
REQ-014 SHALL assert tick exactly SYNC_STAGES+1 clk edges after the first clk edge sampling slow_in high; one pulse per rising edge, none on falling edge.
REQ-015 SHALL implement FSM states IDLE, RUN, PAUSED, DONE.
REQ-016 IDLE: load=1 -> capture preset, stay IDLE; else start=1 and count!=00:00 -> RUN; else start=1 and count=00:00 -> stay IDLE.
REQ-017 SHALL give load priority over start in the same cycle; start ignored that cycle.
REQ-018 SHALL clamp preset on capture: units >9 -> 9, tens >5 -> 5, per digit independently.
REQ-019 RUN: on tick, decrement count by one second with BCD borrow (su 0->9 borrows st; st 0->5 borrows mu; mu 0->9 borrows mt).
REQ-020 RUN: tick that brings count to 00:00 -> DONE on the same edge the count updates.
REQ-021 RUN: pause=1 -> PAUSED; if tick in the same cycle, decrement applied first, then PAUSED (or DONE if 00:00 reached, DONE wins).
REQ-022 PAUSED: ticks ignored, count frozen; pause=1 -> RUN; load=1 -> capture preset and go IDLE (load wins over pause).
REQ-023 DONE: count held 00:00; load=1 -> capture preset, go IDLE; start/pause ignored.
REQ-024 SHALL treat pause and start as rising-edge events internally (one registered copy each) so a held level acts once.
REQ-025 load, start, pause SHALL be ignored in states not listed above; load in RUN ignored.
REQ-026 count SHALL never underflow below 00:00 nor hold non-BCD values.
REQ-027 running and done SHALL be registered decodes of the FSM state, valid the cycle the state is entered.

Reset
REQ-028 rst_n low SHALL immediately clear: FSM to IDLE, count to 00:00, running=0, done=0, tick=0, all synchronizer, history and edge-detect flops to 0.
REQ-029 Reset mid-RUN SHALL abort the count with no done pulse; after release first tick requires a fresh slow_in rising edge.
REQ-030 SHALL treat rst_n deassertion asynchronously-asserted, synchronously-effective: first state change no earlier than first clk edge after release.

Verification
REQ-031 Preset 00:03, load, start, 4 slow_in rising edges -> count 02,01,00; done=1 after third tick, running=0; fourth tick no change.
REQ-032 Preset 10:00, run, one tick -> 09:59; preset 01:00 one tick -> 00:59.
REQ-033 Preset set_mu=12, set_st=7 -> captured mu=9, st=5.
REQ-034 RUN at 00:05, pause asserted same cycle as tick -> 00:04, PAUSED; 3 ticks -> still 00:04; pause again -> RUN, next tick 00:03.
REQ-035 start with count 00:00 in IDLE -> stays IDLE, running=0; load+start same cycle with preset 00:02 -> IDLE, count 00:02.
REQ-036 rst_n pulsed low mid-RUN at 00:30 -> outputs 00:00, IDLE, done=0 before next clk edge; slow_in held high through release produces no tick.

Source files
------------

// File: rtl/temporizador_mmss.sv
// mm:ss countdown timer driven by an asynchronous ~1 Hz slow_in.
// BCD count, load/start/pause control, synchronized tick detection.
module temporizador_mmss #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       slow_in,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  input  logic [2:0] set_mt,
  input  logic [3:0] set_mu,
  input  logic [2:0] set_st,
  input  logic [3:0] set_su,
  output logic [2:0] min_t,
  output logic [3:0] min_u,
  output logic [2:0] sec_t,
  output logic [3:0] sec_u,
  output logic       running,
  output logic       done,
  output logic       tick
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSED,
    S_DONE
  } state_t;

  localparam logic [2:0] FILL_MAX = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic [2:0]             fill_q;
  logic                   armed;
  logic                   sync_out;

  logic start_q;
  logic pause_q;
  logic start_ev;
  logic pause_ev;

  state_t state_q;
  state_t state_n;

  logic [2:0] mt_n;
  logic [3:0] mu_n;
  logic [2:0] st_n;
  logic [3:0] su_n;

  logic [2:0] p_mt;
  logic [3:0] p_mu;
  logic [2:0] p_st;
  logic [3:0] p_su;

  logic [2:0] d_mt;
  logic [3:0] d_mu;
  logic [2:0] d_st;
  logic [3:0] d_su;
  logic       b_su;
  logic       b_st;
  logic       b_mu;

  logic is_zero;
  logic last_sec;

  assign sync_out = sync_q[SYNC_STAGES-1];
  // Hold off edge detection until the chain holds real samples,
  // so a level already high at reset release is not seen as an edge.
  assign armed    = (fill_q == FILL_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      fill_q <= 3'd0;
      tick   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], slow_in};
      hist_q <= sync_out;
      if (!armed) begin
        fill_q <= fill_q + 3'd1;
      end
      tick <= armed & sync_out & ~hist_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      pause_q <= 1'b0;
    end else begin
      start_q <= start;
      pause_q <= pause;
    end
  end

  assign start_ev = start & ~start_q;
  assign pause_ev = pause & ~pause_q;

  assign p_mt = (set_mt > 3'd5) ? 3'd5 : set_mt;
  assign p_mu = (set_mu > 4'd9) ? 4'd9 : set_mu;
  assign p_st = (set_st > 3'd5) ? 3'd5 : set_st;
  assign p_su = (set_su > 4'd9) ? 4'd9 : set_su;

  assign is_zero = (min_t == 3'd0) && (min_u == 4'd0) &&
                   (sec_t == 3'd0) && (sec_u == 4'd0);

  assign last_sec = (min_t == 3'd0) && (min_u == 4'd0) &&
                    (sec_t == 3'd0) && (sec_u == 4'd1);

  // One-second BCD decrement with borrow ripple across digits.
  assign b_su = (sec_u == 4'd0);
  assign b_st = b_su && (sec_t == 3'd0);
  assign b_mu = b_st && (min_u == 4'd0);

  assign d_su = b_su ? 4'd9 : sec_u - 4'd1;

  assign d_st = !b_su ? sec_t :
                (sec_t == 3'd0) ? 3'd5 : sec_t - 3'd1;

  assign d_mu = !b_st ? min_u :
                (min_u == 4'd0) ? 4'd9 : min_u - 4'd1;

  assign d_mt = !b_mu ? min_t :
                (min_t == 3'd0) ? 3'd0 : min_t - 3'd1;

  always_comb begin
    state_n = state_q;
    mt_n    = min_t;
    mu_n    = min_u;
    st_n    = sec_t;
    su_n    = sec_u;
    unique case (state_q)
      S_IDLE: begin
        if (load) begin
          mt_n = p_mt;
          mu_n = p_mu;
          st_n = p_st;
          su_n = p_su;
        end else if (start_ev && !is_zero) begin
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        if (tick) begin
          mt_n = d_mt;
          mu_n = d_mu;
          st_n = d_st;
          su_n = d_su;
        end
        if (tick && last_sec) begin
          state_n = S_DONE;
        end else if (pause_ev) begin
          state_n = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (load) begin
          mt_n    = p_mt;
          mu_n    = p_mu;
          st_n    = p_st;
          su_n    = p_su;
          state_n = S_IDLE;
        end else if (pause_ev) begin
          state_n = S_RUN;
        end
      end
      S_DONE: begin
        if (load) begin
          mt_n    = p_mt;
          mu_n    = p_mu;
          st_n    = p_st;
          su_n    = p_su;
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      min_t   <= 3'd0;
      min_u   <= 4'd0;
      sec_t   <= 3'd0;
      sec_u   <= 4'd0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_n;
      min_t   <= mt_n;
      min_u   <= mu_n;
      sec_t   <= st_n;
      sec_u   <= su_n;
      running <= (state_n == S_RUN);
      done    <= (state_n == S_DONE);
    end
  end

endmodule

// File: tb/tb_temporizador_mmss.sv
// Bench for temporizador_mmss: seconds-level model plus
// directed scenarios with literal expectations.
module tb_temporizador_mmss;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       slow_in = 1'b0;
  logic       load = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [2:0] set_mt = '0;
  logic [3:0] set_mu = '0;
  logic [2:0] set_st = '0;
  logic [3:0] set_su = '0;
  logic [2:0] min_t;
  logic [3:0] min_u;
  logic [2:0] sec_t;
  logic [3:0] sec_u;
  logic       running;
  logic       done;
  logic       tick;

  int checks = 0;
  int errors = 0;
  int tick_seen = 0;

  temporizador_mmss #(.SYNC_STAGES(S)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .slow_in (slow_in),
    .load    (load),
    .start   (start),
    .pause   (pause),
    .set_mt  (set_mt),
    .set_mu  (set_mu),
    .set_st  (set_st),
    .set_su  (set_su),
    .min_t   (min_t),
    .min_u   (min_u),
    .sec_t   (sec_t),
    .sec_u   (sec_u),
    .running (running),
    .done    (done),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", n, act, exp, $time);
    end
  endtask

  // Model: state 0 idle, 1 run, 2 paused, 3 done; count in seconds.
  int  m_state = 0;
  int  m_secs = 0;
  bit  m_tick = 0;
  bit  m_sp = 0;
  bit  m_pp = 0;
  int  m_k = 0;
  bit  smp[$];
  bit  tk;
  bit  sev;
  bit  pev;

  function automatic int clampsecs(input int mt, input int mu,
                                   input int st, input int su);
    int a, b, c, d;
    a = (mt > 5) ? 5 : mt;
    b = (mu > 9) ? 9 : mu;
    c = (st > 5) ? 5 : st;
    d = (su > 9) ? 9 : su;
    return (a * 10 + b) * 60 + c * 10 + d;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0;
      m_secs  = 0;
      m_tick  = 0;
      m_sp    = 0;
      m_pp    = 0;
      m_k     = 0;
      smp.delete();
    end else begin
      tk   = m_tick;
      sev  = start && !m_sp;
      pev  = pause && !m_pp;
      m_sp = start;
      m_pp = pause;
      smp.push_back(slow_in);
      m_k++;
      // A high sample reaches tick S edges after the edge that took it.
      m_tick = (m_k >= S + 2) && smp[m_k-S-1] && !smp[m_k-S-2];
      case (m_state)
        0: begin
          if (load) m_secs = clampsecs(set_mt, set_mu, set_st, set_su);
          else if (sev && m_secs != 0) m_state = 1;
        end
        1: begin
          if (tk) m_secs--;
          if (tk && m_secs == 0) m_state = 3;
          else if (pev) m_state = 2;
        end
        2: begin
          if (load) begin
            m_secs  = clampsecs(set_mt, set_mu, set_st, set_su);
            m_state = 0;
          end else if (pev) begin
            m_state = 1;
          end
        end
        default: begin
          if (load) begin
            m_secs  = clampsecs(set_mt, set_mu, set_st, set_su);
            m_state = 0;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    int mm;
    int ss;
    mm = m_secs / 60;
    ss = m_secs % 60;
    if (tick) tick_seen++;
    chk("m_min_t", min_t, mm / 10);
    chk("m_min_u", min_u, mm % 10);
    chk("m_sec_t", sec_t, ss / 10);
    chk("m_sec_u", sec_u, ss % 10);
    chk("m_running", running, (m_state == 1) ? 1 : 0);
    chk("m_done", done, (m_state == 3) ? 1 : 0);
    chk("m_tick", tick, m_tick ? 1 : 0);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic preset(input int mt, input int mu,
                        input int st, input int su);
    set_mt = 3'(mt);
    set_mu = 4'(mu);
    set_st = 3'(st);
    set_su = 4'(su);
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    cyc(1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
  endtask

  task automatic pulse_pause();
    pause = 1'b1;
    cyc(1);
    pause = 1'b0;
    cyc(1);
  endtask

  task automatic slow_pulse();
    slow_in = 1'b1;
    cyc(6);
    slow_in = 1'b0;
    cyc(6);
  endtask

  initial begin
    #1;
    chk("rst_sec_u", sec_u, 0);
    chk("rst_running", running, 0);
    chk("rst_done", done, 0);
    chk("rst_tick", tick, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(8);

    preset(0, 12, 7, 3);
    chk("clamp_mu", min_u, 9);
    chk("clamp_st", sec_t, 5);
    chk("clamp_su_keep", sec_u, 3);
    preset(7, 12, 7, 15);
    chk("clamp_mt", min_t, 5);
    chk("clamp_su", sec_u, 9);

    preset(0, 0, 0, 3);
    pulse_start();
    chk("run_003", running, 1);
    slow_pulse();
    chk("cnt_002", sec_u, 2);
    slow_pulse();
    chk("cnt_001", sec_u, 1);
    slow_pulse();
    chk("cnt_000", sec_u, 0);
    chk("done_hi", done, 1);
    chk("run_lo", running, 0);
    slow_pulse();
    chk("done_hold_su", sec_u, 0);
    chk("done_hold", done, 1);

    preset(1, 0, 0, 0);
    pulse_start();
    slow_pulse();
    chk("b1000_mt", min_t, 0);
    chk("b1000_mu", min_u, 9);
    chk("b1000_st", sec_t, 5);
    chk("b1000_su", sec_u, 9);
    pulse_pause();
    chk("paused_run_lo", running, 0);
    preset(0, 1, 0, 0);
    pulse_start();
    slow_pulse();
    chk("b0100_mu", min_u, 0);
    chk("b0100_st", sec_t, 5);
    chk("b0100_su", sec_u, 9);

    pulse_pause();
    preset(0, 0, 0, 5);
    pulse_start();
    slow_in = 1'b1;
    cyc(2);
    chk("tick_early", tick, 0);
    cyc(1);
    chk("tick_at_s1", tick, 1);
    pause = 1'b1;
    cyc(1);
    pause = 1'b0;
    chk("pz_su", sec_u, 4);
    chk("pz_running", running, 0);
    chk("pz_done", done, 0);
    cyc(5);
    slow_in = 1'b0;
    cyc(6);
    slow_pulse();
    slow_pulse();
    slow_pulse();
    chk("pz_frozen", sec_u, 4);
    pulse_pause();
    chk("resume", running, 1);
    slow_pulse();
    chk("resume_su", sec_u, 3);

    pulse_pause();
    preset(0, 0, 3, 0);
    pulse_start();
    chk("r30_run", running, 1);
    chk("r30_st", sec_t, 3);
    slow_in = 1'b1;
    cyc(1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_st", sec_t, 0);
    chk("arst_su", sec_u, 0);
    chk("arst_running", running, 0);
    chk("arst_done", done, 0);
    chk("arst_tick", tick, 0);
    cyc(1);
    rst_n = 1'b1;
    tick_seen = 0;
    cyc(12);
    chk("no_tick_after_rst", tick_seen, 0);
    slow_in = 1'b0;
    cyc(2);

    pulse_start();
    chk("start_zero", running, 0);
    set_mt = 3'd0;
    set_mu = 4'd0;
    set_st = 3'd0;
    set_su = 4'd2;
    load = 1'b1;
    start = 1'b1;
    cyc(1);
    load = 1'b0;
    start = 1'b0;
    cyc(1);
    chk("ld_st_idle", running, 0);
    chk("ld_st_su", sec_u, 2);
    pulse_start();
    chk("start_after", running, 1);
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
